// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - state_t   : controller states (IDLE, CALC, FIN)
//   - N_W_DEF   : default dividend / quotient width
//   - D_W_DEF   : default divisor / remainder width
//   - CNT_W     : iteration counter width for the default dividend width
//   - DBZ_QUOT  : quotient reported for a zero divisor (all ones)
package div_pkg;

  localparam int unsigned N_W_DEF = 8;
  localparam int unsigned D_W_DEF = 4;
  localparam int unsigned CNT_W   = $clog2(N_W_DEF);

  localparam logic [N_W_DEF-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
//   rem_in  [D_W:0]   partial remainder from the previous step
//   bit_in            next dividend bit (MSB first)
//   divisor [D_W-1:0] divisor
//   rem_out [D_W:0]   partial remainder after shift and conditional subtract
//   q_bit             quotient bit produced by this step
module div_restore_step #(
  parameter int unsigned D_W = 4
) (
  input  logic [D_W:0]   rem_in,
  input  logic           bit_in,
  input  logic [D_W-1:0] divisor,
  output logic [D_W:0]   rem_out,
  output logic           q_bit
);

  // Kept one bit wider than the partial remainder so the shift never loses
  // information; after a valid step the top bit is always zero.
  logic [D_W+1:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    if (shifted >= {2'b00, divisor}) begin
      rem_out = (D_W+1)'(shifted - {2'b00, divisor});
      q_bit   = 1'b1;
    end else begin
      rem_out = (D_W+1)'(shifted);
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/divider_8_by_4_seq.sv
// Sequential restoring divider: N_W-bit unsigned dividend by D_W-bit unsigned
// divisor, one quotient bit per clock, start/done handshake.
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        request; sampled only in IDLE
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse when results become valid
//   quotient     result quotient, updated only on entry to FIN
//   remainder    result remainder, updated only on entry to FIN
//   div_by_zero  set with done when the divisor was zero; cleared on next accept
module divider_8_by_4_seq
  import div_pkg::*;
#(
  parameter int unsigned N_W = N_W_DEF,
  parameter int unsigned D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  localparam int unsigned CW = $clog2(N_W);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N_W-1:0] dvd_q, dvd_d;
  logic [D_W-1:0] dvs_q, dvs_d;
  logic [D_W:0]   part_q, part_d;
  logic [N_W-1:0] quotient_q, quotient_d;
  logic [D_W-1:0] remainder_q, remainder_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [D_W:0]   step_rem;
  logic           step_q;

  div_restore_step #(.D_W(D_W)) u_step (
    .rem_in  (part_q),
    .bit_in  (dvd_q[N_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The dividend register doubles as the quotient accumulator: each step
  // consumes its MSB and shifts the new quotient bit in at the LSB, so after
  // N_W steps it holds the complete quotient.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            part_d  = '0;
            cnt_d   = CW'(N_W - 1);
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend[D_W-1:0];
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = FIN;
          end
        end
      end

      CALC: begin
        part_d = step_rem;
        dvd_d  = {dvd_q[N_W-2:0], step_q};
        if (cnt_q == '0) begin
          quotient_d  = {dvd_q[N_W-2:0], step_q};
          remainder_d = step_rem[D_W-1:0];
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_8_by_4_seq.sv
// Self-checking bench for divider_8_by_4_seq: directed vector table plus
// hand-written handshake, reset-abort and full operand sweep sequences.
module tb_divider_8_by_4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  divider_8_by_4_seq #(.N_W(8), .D_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t tbl [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for done after an accept edge; returns edges counted.
  task automatic wait_done(input int start_lat, output int lat, output int bcy);
    lat = start_lat;
    bcy = 0;
    while (!done && lat < 20) begin
      if (busy) bcy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edbz, input int elat, input bit full);
    int lat, bcy;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    wait_done(0, lat, bcy);
    chk("latency", lat, elat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edbz);
    if (full) begin
      chk("busy_cycles", bcy, elat);
      chk("busy_at_done", busy, 0);
    end
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    if (full) chk("quotient_held", quotient, eq);
  endtask

  initial begin
    int  lat, bcy;
    bit  seen;

    tbl[0]  = '{8'd120, 4'd12, 8'd10,  4'd0, 1'b0, 8};
    tbl[1]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
    tbl[2]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
    tbl[3]  = '{8'd7,   4'd9,  8'd0,   4'd7, 1'b0, 8};
    tbl[4]  = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8};
    tbl[5]  = '{8'd200, 4'd12, 8'd16,  4'd8, 1'b0, 8};
    tbl[6]  = '{8'd100, 4'd0,  8'hFF,  4'd4, 1'b1, 0};
    tbl[7]  = '{8'd13,  4'd3,  8'd4,   4'd1, 1'b0, 8};
    tbl[8]  = '{8'd1,   4'd15, 8'd0,   4'd1, 1'b0, 8};
    tbl[9]  = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1, 0};
    tbl[10] = '{8'd14,  4'd14, 8'd1,   4'd0, 1'b0, 8};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);

    for (int i = 0; i < 11; i++)
      do_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat, 1'b1);

    // Back-to-back with start held high: 156/12 then 180/15.
    @(negedge clk);
    dividend = 8'd156;
    divisor  = 4'd12;
    start    = 1'b1;
    @(posedge clk); #1;
    dividend = 8'd180;
    divisor  = 4'd15;
    wait_done(0, lat, bcy);
    chk("b2b_first_latency", lat, 8);
    chk("b2b_first_quotient", quotient, 13);
    chk("b2b_first_remainder", remainder, 0);
    @(posedge clk); #1;
    chk("b2b_idle_done", done, 0);
    chk("b2b_idle_busy", busy, 0);
    @(posedge clk); #1;
    chk("b2b_second_accept_busy", busy, 1);
    wait_done(0, lat, bcy);
    start = 1'b0;
    chk("b2b_second_latency", lat, 8);
    chk("b2b_second_quotient", quotient, 12);
    chk("b2b_second_remainder", remainder, 0);
    @(posedge clk); #1;
    chk("b2b_second_pulse_width", done, 0);

    // Operand changes and a stray start pulse during CALC are ignored.
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'd255;
    divisor  = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat, bcy);
    chk("calc_ignore_latency", lat, 8);
    chk("calc_ignore_quotient", quotient, 11);
    chk("calc_ignore_remainder", remainder, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("calc_ignore_no_second_done", seen, 0);

    // Reset after step 4 of 8 aborts the operation.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd12;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_mid_calc", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);

    // Exhaustive sweep of nonzero divisors.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 8, 1'b0);
        chk("sweep_identity", quotient * b + remainder, a);
        chk("sweep_rem_lt_div", (remainder < b) ? 1 : 0, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
